// File: rtl/phase_freq_est.sv
// Phase-to-frequency estimator: modular phase differences, averaged
// over 2**AVG_LOG2 steps, emitted as a magnitude/direction pair.
module phase_freq_est #(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             phase_vld,
    input  logic [WIDTH-1:0] phase_in,
    output logic [WIDTH-1:0] freq_out,
    output logic             dir,
    output logic             freq_vld
);

    localparam int SW = WIDTH + AVG_LOG2;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   take_ref;
    logic                   take_delta;
    logic                   win_done;
    logic                   win_out;
    logic [WIDTH-1:0]       prev;
    logic signed [SW-1:0]   sum;
    logic signed [SW-1:0]   sum_nxt;
    logic signed [WIDTH-1:0] delta;
    logic signed [WIDTH-1:0] avg;
    logic [WIDTH-1:0]       mag;

    // State register: EMPTY until a reference sample has been captured
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clr drops the reference, any sample establishes one
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = EMPTY;
        end else if (phase_vld) begin
            state_nxt = RUN;
        end
    end

    // State decode: what an accepted sample is used for
    always_comb begin
        take_ref   = 1'b0;
        take_delta = 1'b0;
        if (phase_vld && !clr) begin
            unique case (state)
                EMPTY: take_ref   = 1'b1;
                RUN:   take_delta = 1'b1;
            endcase
        end
    end

    // Window position; with no averaging every delta closes a window
    generate
        if (AVG_LOG2 == 0) begin : g_no_avg
            assign win_done = 1'b1;
        end else begin : g_avg
            logic [AVG_LOG2-1:0] cnt;

            // Count deltas in the window, wrapping to 0 on completion
            always_ff @(posedge clock) begin
                if (reset || clr) begin
                    cnt <= '0;
                end else if (take_delta) begin
                    cnt <= cnt + AVG_LOG2'(1);
                end
            end

            assign win_done = &cnt;
        end
    endgenerate

    // Modular difference read as two's complement, then windowed mean
    always_comb begin
        delta   = phase_in - prev;
        sum_nxt = sum + SW'(delta);
        avg     = sum_nxt[SW-1:AVG_LOG2];
        mag     = avg[WIDTH-1] ? WIDTH'(-avg) : WIDTH'(avg);
        win_out = take_delta && win_done;
    end

    // Reference sample and running sum; prev survives window boundaries
    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= '0;
            sum  <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (take_ref) begin
            prev <= phase_in;
        end else if (take_delta) begin
            prev <= phase_in;
            sum  <= win_done ? '0 : sum_nxt;
        end
    end

    // Result registers: one-cycle strobe, value held between windows
    always_ff @(posedge clock) begin
        if (reset) begin
            freq_out <= '0;
            dir      <= 1'b0;
            freq_vld <= 1'b0;
        end else begin
            freq_vld <= win_out;
            if (win_out) begin
                freq_out <= mag;
                dir      <= avg[WIDTH-1];
            end
        end
    end

endmodule
